// File: rtl/vram_arbiter.sv
// vram_arbiter: time-shares one single-port synchronous-read text RAM between
// the character fetch (fixed slot per 8-pixel cell) and a req/ack host port.
module vram_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COLS     = 80,
  parameter int ROWS     = 30,
  parameter int AW       = 12
) (
  input  logic          clock25,
  input  logic          reset_n,
  input  logic [9:0]    HorizontalCounter,
  input  logic [9:0]    VerticalCounter,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic          host_ack,
  output logic [7:0]    host_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic [7:0]    char_code,
  output logic          char_valid
);

  localparam logic [9:0]    H_LIM    = 10'(H_ACTIVE);
  localparam logic [9:0]    V_LIM    = 10'(V_ACTIVE);
  localparam logic [AW-1:0] COLS_AW  = AW'(COLS);
  localparam logic [AW-1:0] CELLS_AW = AW'(COLS * ROWS);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    ACK
  } host_state_t;

  host_state_t   state;
  logic          disp_slot;
  logic [AW-1:0] disp_addr;
  logic [AW-1:0] row_idx;
  logic [AW-1:0] col_idx;
  logic          host_slot;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_wdata;
  logic          req_we;
  logic          req_in_range;
  logic          fetch_d1;

  // Reset gates the slot so the RAM port is quiet while reset is held.
  assign disp_slot = reset_n && (HorizontalCounter[2:0] == 3'd0) &&
                     (HorizontalCounter < H_LIM) && (VerticalCounter < V_LIM);

  assign row_idx   = {{(AW-6){1'b0}}, VerticalCounter[9:4]};
  assign col_idx   = {{(AW-7){1'b0}}, HorizontalCounter[9:3]};
  assign disp_addr = row_idx * COLS_AW + col_idx;

  assign host_slot = (state == ISSUE) && !disp_slot;

  always_comb begin
    ram_addr  = last_addr;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (disp_slot) begin
      ram_addr = disp_addr;
    end else if (host_slot && req_in_range) begin
      ram_addr  = req_addr;
      ram_we    = req_we;
      ram_wdata = req_wdata;
    end
  end

  // Request fields are captured on acceptance so a dropped req still completes.
  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      host_ack     <= 1'b0;
      host_rdata   <= 8'h00;
      req_addr     <= '0;
      req_wdata    <= 8'h00;
      req_we       <= 1'b0;
      req_in_range <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (host_req) begin
            req_addr     <= host_addr;
            req_wdata    <= host_wdata;
            req_we       <= host_we;
            req_in_range <= (host_addr < CELLS_AW);
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (!disp_slot) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (!req_we) begin
            host_rdata <= req_in_range ? ram_rdata : 8'h00;
          end
          host_ack <= 1'b1;
          state    <= ACK;
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock25 or negedge reset_n) begin
    if (!reset_n) begin
      fetch_d1   <= 1'b0;
      char_valid <= 1'b0;
      char_code  <= 8'h00;
      last_addr  <= '0;
    end else begin
      fetch_d1   <= disp_slot;
      char_valid <= fetch_d1;
      if (fetch_d1) begin
        char_code <= ram_rdata;
      end
      last_addr <= ram_addr;
    end
  end

  // Display owns its slot outright; acks are single-cycle pulses.
  assert property (@(posedge clock25) disable iff (!reset_n) disp_slot |-> !ram_we);
  assert property (@(posedge clock25) disable iff (!reset_n) host_ack |=> !host_ack);

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed table vectors, hand-written corner sequences and a
// randomized soak, all cross-checked by a cycle-level model of the arbiter rules.
module tb_vram_arbiter;

  logic        clock25 = 1'b0;
  logic        reset_n;
  logic [9:0]  HorizontalCounter;
  logic [9:0]  VerticalCounter;
  logic        host_req;
  logic        host_we;
  logic [11:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  char_code;
  logic        char_valid;
  logic        load_en;

  int checks   = 0;
  int failures = 0;
  int hc = 0;
  int vc = 0;

  logic [7:0] mem    [0:4095];
  logic [7:0] shadow [0:4095];

  vram_arbiter dut (
    .clock25(clock25),
    .reset_n(reset_n),
    .HorizontalCounter(HorizontalCounter),
    .VerticalCounter(VerticalCounter),
    .host_req(host_req),
    .host_we(host_we),
    .host_addr(host_addr),
    .host_wdata(host_wdata),
    .host_ack(host_ack),
    .host_rdata(host_rdata),
    .ram_addr(ram_addr),
    .ram_we(ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .char_code(char_code),
    .char_valid(char_valid)
  );

  always #20 clock25 = ~clock25;

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 29 + 7) ^ (a >> 3));
  endfunction

  // Text RAM: single port, read-before-write, one-cycle read latency.
  always @(posedge clock25) begin
    if (load_en) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(i);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at time %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: evaluated every cycle from the arbitration rules alone.
  typedef struct {
    int         due;
    logic [7:0] code;
  } char_exp_t;

  char_exp_t   dq[$];
  int          cyc = 0;
  logic        busy = 1'b0;
  logic        accessed = 1'b0;
  int          ack_cycle = 0;
  logic        m_we = 1'b0;
  logic        m_in_range = 1'b0;
  logic [11:0] m_addr = '0;
  logic [7:0]  m_wdata = '0;
  logic [7:0]  m_rdata = '0;
  logic [11:0] exp_last = '0;

  always @(negedge clock25) begin : model
    int          h;
    int          v;
    logic        slot;
    logic        idle_now;
    logic        exp_we;
    logic        exp_ack;
    logic        exp_valid;
    logic [11:0] exp_addr;
    #2;
    cyc++;
    if (load_en) begin
      for (int i = 0; i < 4096; i++) shadow[i] = init_val(i);
    end
    if (!reset_n) begin
      busy     = 1'b0;
      accessed = 1'b0;
      exp_last = '0;
      dq.delete();
      check_output("reset_outputs",
                   {host_ack, host_rdata, ram_addr, ram_we, ram_wdata, char_code, char_valid}, 64'd0);
    end else begin
      h = int'(HorizontalCounter);
      v = int'(VerticalCounter);
      slot = (h % 8 == 0) && (h < 640) && (v < 480);
      idle_now = !busy;
      exp_we = 1'b0;
      exp_addr = exp_last;
      if (slot) begin
        exp_addr = 12'((v / 16) * 80 + h / 8);
      end else if (busy && !accessed) begin
        accessed = 1'b1;
        ack_cycle = cyc + 2;
        if (m_in_range) begin
          exp_we = m_we;
          exp_addr = m_addr;
          if (m_we) shadow[m_addr] = m_wdata;
          else m_rdata = shadow[m_addr];
        end else begin
          m_rdata = 8'h00;
        end
      end
      check_output("ram_we", ram_we, exp_we);
      check_output("ram_addr", ram_addr, exp_addr);
      if (exp_we) check_output("ram_wdata", ram_wdata, m_wdata);
      exp_last = exp_addr;

      exp_ack = busy && accessed && (cyc == ack_cycle);
      check_output("host_ack", host_ack, exp_ack);
      if (exp_ack) begin
        if (!m_we) check_output("host_rdata", host_rdata, m_rdata);
        busy = 1'b0;
      end
      if (idle_now && host_req) begin
        busy = 1'b1;
        accessed = 1'b0;
        m_we = host_we;
        m_addr = host_addr;
        m_wdata = host_wdata;
        m_in_range = (int'(host_addr) < 2400);
      end

      if (slot) dq.push_back('{cyc + 2, mem[exp_addr]});
      exp_valid = (dq.size() > 0) && (dq[0].due == cyc);
      check_output("char_valid", char_valid, exp_valid);
      if (exp_valid) begin
        check_output("char_code", char_code, dq[0].code);
        void'(dq.pop_front());
      end
    end
  end

  task automatic tick();
    @(negedge clock25);
    HorizontalCounter = 10'(hc);
    VerticalCounter = 10'(vc);
    hc++;
    if (hc == 800) begin
      hc = 0;
      vc++;
      if (vc == 525) vc = 0;
    end
  endtask

  task automatic host_transaction(input logic we, input logic [11:0] addr, input logic [7:0] wdata,
                                  output logic [7:0] rdata);
    logic got;
    tick();
    host_req = 1'b1;
    host_we = we;
    host_addr = addr;
    host_wdata = wdata;
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      #3;
      if (host_ack) begin
        got = 1'b1;
        break;
      end
    end
    check_output("host_ack_seen", got, 1'b1);
    rdata = host_rdata;
    tick();
    host_req = 1'b0;
  endtask

  typedef struct {
    int          v;
    int          h;
    logic        slot;
    logic [11:0] addr;
  } disp_vec_t;

  task automatic apply_stimulus(input disp_vec_t d);
    hc = d.h;
    vc = d.v;
    tick();
    #3;
    if (d.slot) begin
      check_output("vec_ram_addr", ram_addr, d.addr);
      check_output("vec_ram_we", ram_we, 1'b0);
    end
    tick();
    tick();
    #3;
    check_output("vec_char_valid", char_valid, d.slot);
    if (d.slot) check_output("vec_char_code", char_code, init_val(int'(d.addr)));
  endtask

  task automatic soak(input int start_v, input int ncycles);
    int   issued;
    int   acked;
    int   wait_cnt;
    logic active;
    issued = 0;
    acked = 0;
    wait_cnt = 0;
    active = 1'b0;
    hc = 0;
    vc = start_v;
    for (int c = 0; c < ncycles; c++) begin
      tick();
      if (!active) begin
        if ($urandom_range(0, 2) == 0) begin
          active = 1'b1;
          wait_cnt = 0;
          host_req = 1'b1;
          host_we = 1'($urandom_range(0, 1));
          host_addr = ($urandom_range(0, 19) == 0) ? 12'(2400 + $urandom_range(0, 1695))
                                                     : 12'($urandom_range(0, 2399));
          host_wdata = 8'($urandom);
          issued++;
        end else begin
          host_req = 1'b0;
        end
      end
      #3;
      if (active) begin
        if (host_ack) begin
          acked++;
          active = 1'b0;
        end else begin
          wait_cnt++;
          if (wait_cnt > 20) begin
            check_output("soak_ack_timeout", 1'b0, 1'b1);
            active = 1'b0;
          end
        end
      end
    end
    for (int n = 0; n < 30 && active; n++) begin
      tick();
      #3;
      if (host_ack) begin
        acked++;
        active = 1'b0;
      end
    end
    tick();
    host_req = 1'b0;
    check_output("soak_ack_count", acked, issued);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    disp_vec_t   dvec[9];
    logic [7:0]  rd;
    int          bad;

    dvec[0] = '{0,   0,   1'b1, 12'd0};
    dvec[1] = '{0,   632, 1'b1, 12'd79};
    dvec[2] = '{16,  0,   1'b1, 12'd80};
    dvec[3] = '{100, 8,   1'b1, 12'd481};
    dvec[4] = '{255, 320, 1'b1, 12'd1240};
    dvec[5] = '{479, 632, 1'b1, 12'd2399};
    dvec[6] = '{0,   640, 1'b0, 12'd0};
    dvec[7] = '{480, 0,   1'b0, 12'd0};
    dvec[8] = '{10,  3,   1'b0, 12'd0};

    reset_n = 1'b1;
    load_en = 1'b0;
    host_req = 1'b0;
    host_we = 1'b0;
    host_addr = '0;
    host_wdata = '0;
    HorizontalCounter = '0;
    VerticalCounter = '0;
    hc = 700;
    vc = 0;
    #1 reset_n = 1'b0;
    tick();
    load_en = 1'b1;
    tick();
    load_en = 1'b0;
    tick();
    #3;
    check_output("reset_idle", {host_ack, ram_we, char_valid, ram_addr}, 64'd0);
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) apply_stimulus(dvec[i]);

    // Display fetch of a freshly written cell.
    hc = 700;
    vc = 32;
    host_transaction(1'b1, 12'd165, 8'h41, rd);
    hc = 40;
    vc = 32;
    tick();
    #3;
    check_output("t2_ram_addr", ram_addr, 12'd165);
    check_output("t2_ram_we", ram_we, 1'b0);
    tick();
    tick();
    #3;
    check_output("t2_char_valid", char_valid, 1'b1);
    check_output("t2_char_code", char_code, 8'h41);

    // Host write in blanking, cycle by cycle.
    hc = 700;
    vc = 100;
    tick();
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 12'h010;
    host_wdata = 8'h5A;
    tick();
    #3;
    check_output("t3_we_pulse", {ram_we, ram_addr, ram_wdata}, {1'b1, 12'h010, 8'h5A});
    check_output("t3_early_ack", host_ack, 1'b0);
    tick();
    #3;
    check_output("t3_we_single", ram_we, 1'b0);
    check_output("t3_mid_ack", host_ack, 1'b0);
    tick();
    #3;
    check_output("t3_ack", host_ack, 1'b1);
    tick();
    host_req = 1'b0;
    #3;
    check_output("t3_ack_single", host_ack, 1'b0);

    // Host read whose issue cycle collides with the H=8 display slot.
    hc = 7;
    vc = 50;
    tick();
    host_req = 1'b1;
    host_we = 1'b0;
    host_addr = 12'd165;
    tick();
    #3;
    check_output("t4_disp_addr", {ram_we, ram_addr}, {1'b0, 12'd241});
    tick();
    #3;
    check_output("t4_host_addr", {ram_we, ram_addr}, {1'b0, 12'd165});
    check_output("t4_no_ack", host_ack, 1'b0);
    tick();
    #3;
    check_output("t4_char_valid", char_valid, 1'b1);
    check_output("t4_char_code", char_code, init_val(241));
    check_output("t4_capture_no_ack", host_ack, 1'b0);
    tick();
    #3;
    check_output("t4_ack", host_ack, 1'b1);
    check_output("t4_rdata", host_rdata, 8'h41);
    tick();
    host_req = 1'b0;

    // Reset asserted while the FSM is in ISSUE.
    hc = 700;
    vc = 300;
    tick();
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 12'd20;
    host_wdata = 8'hC3;
    tick();
    reset_n = 1'b0;
    #3;
    check_output("t1_reset_outputs",
                 {host_ack, host_rdata, ram_addr, ram_we, ram_wdata, char_code, char_valid}, 64'd0);
    host_req = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      #3;
      check_output("t1_no_ack", host_ack, 1'b0);
    end

    hc = 700;
    vc = 310;
    host_transaction(1'b0, 12'h010, 8'h00, rd);
    check_output("read_back", rd, 8'h5A);

    // Out-of-range read clears host_rdata without touching the RAM.
    host_transaction(1'b0, 12'd2400, 8'h00, rd);
    check_output("t5_rdata", rd, 8'h00);

    soak(472, 8000);
    soak(522, 5600);

    tick();
    tick();
    bad = 0;
    for (int i = 0; i < 2400; i++) begin
      if (mem[i] !== shadow[i]) bad++;
    end
    check_output("ram_contents", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
